// File: rtl/maple_tx_sequencer.sv
// rtl/maple_tx_sequencer.sv - tick-paced Maple bus transmit sequencer
// Frames bytes as lead, start toggles, MSB-first bit pairs and end pattern.
module maple_tx_sequencer #(
  parameter int unsigned START_TOGGLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       out_p1,
  output logic       out_p5,
  output logic       oe,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SLOW, S_STOG, S_DATA, S_END} state_t;

  localparam logic [3:0] TOG_LAST = 4'(START_TOGGLES - 1);
  // End pattern per tick, bit i is the value driven on the i-th END tick.
  localparam logic [6:0] END_P1 = 7'b1000001;
  localparam logic [6:0] END_P5 = 7'b1101011;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] pair_q, pair_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] shift_q, shift_d;
  logic       last_q, last_d;
  logic       err_q, err_d;
  logic       p1_q, p1_d, p5_q, p5_d, oe_q, oe_d, busy_q, busy_d;
  logic       ready_q, ready_d, done_q, done_d, unr_q, unr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pair_d  = pair_q;
    phase_d = phase_q;
    shift_d = shift_q;
    last_d  = last_q;
    err_d   = err_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    unr_d   = 1'b0;
    p1_d    = p1_q;
    p5_d    = p5_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    if (tick) begin
      case (state_q)
        S_IDLE: if (tx_valid) begin
          shift_d = tx_data;
          last_d  = tx_last;
          ready_d = 1'b1;
          state_d = S_LEAD;
        end
        S_LEAD: state_d = S_SLOW;
        S_SLOW: begin
          state_d = S_STOG;
          cnt_d   = 4'd0;
        end
        // p1 itself marks the half-pulse; cnt counts completed low/high pulses.
        S_STOG: if (p1_q) begin
          if (cnt_q == TOG_LAST) begin
            state_d = S_DATA;
            pair_d  = 2'd0;
            phase_d = 2'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (pair_q != 2'd3) begin
              pair_d  = pair_q + 2'd1;
              shift_d = {shift_q[5:0], 2'b00};
            end else if (last_q) begin
              state_d = S_END;
              cnt_d   = 4'd0;
            end else if (tx_valid) begin
              shift_d = tx_data;
              last_d  = tx_last;
              ready_d = 1'b1;
              pair_d  = 2'd0;
            end else begin
              err_d   = 1'b1;
              state_d = S_END;
              cnt_d   = 4'd0;
            end
          end
        end
        S_END: if (cnt_q == 4'd6) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          unr_d   = err_q;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
        default: state_d = S_IDLE;
      endcase

      p1_d   = 1'b1;
      p5_d   = 1'b1;
      oe_d   = 1'b1;
      busy_d = 1'b1;
      case (state_d)
        S_IDLE: begin
          oe_d   = 1'b0;
          busy_d = 1'b0;
        end
        S_LEAD: p5_d = 1'b1;
        S_SLOW: p5_d = 1'b0;
        S_STOG: begin
          p5_d = 1'b0;
          p1_d = ~p1_q;
        end
        S_DATA: case (phase_d)
          2'd0: begin p1_d = 1'b1;       p5_d = shift_d[7]; end
          2'd1: begin p1_d = 1'b0;       p5_d = shift_d[7]; end
          2'd2: begin p1_d = shift_d[6]; p5_d = 1'b1;       end
          default: begin p1_d = shift_d[6]; p5_d = 1'b0;    end
        endcase
        S_END: begin
          p1_d = END_P1[cnt_d[2:0]];
          p5_d = END_P5[cnt_d[2:0]];
        end
        default: oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pair_q  <= 2'd0;
      phase_q <= 2'd0;
      shift_q <= 8'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      p1_q    <= 1'b1;
      p5_q    <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      err_q   <= err_d;
      p1_q    <= p1_d;
      p5_q    <= p5_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      unr_q   <= unr_d;
    end
  end

  assign tx_ready = ready_q;
  assign out_p1   = p1_q;
  assign out_p5   = p5_q;
  assign oe       = oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = unr_q;

endmodule

// File: tb/tb_maple_tx_sequencer.sv
// tb/tb_maple_tx_sequencer.sv - scoreboard bench for maple_tx_sequencer
module tb_maple_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_valid2 = 1'b0;

  logic a_ready, a_p1, a_p5, a_oe, a_busy, a_done, a_ur;
  logic b_ready, b_p1, b_p5, b_oe, b_busy, b_done, b_ur;

  maple_tx_sequencer #(.START_TOGGLES(4)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(a_ready), .out_p1(a_p1), .out_p5(a_p5),
    .oe(a_oe), .busy(a_busy), .done(a_done), .underrun(a_ur));

  maple_tx_sequencer #(.START_TOGGLES(2)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid2), .tx_ready(b_ready), .out_p1(b_p1), .out_p5(b_p5),
    .oe(b_oe), .busy(b_busy), .done(b_done), .underrun(b_ur));

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] rec;
    int         len;
    int         rdy;
  } exp_t;

  exp_t       exp_a[$];
  exp_t       exp_b[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       tick_seen = 1'b0;
  logic [6:0] prev [2];
  int         oe_cnt [2];
  int         rdy_cnt [2];
  int         push_cnt, push_lim;
  int         tick_period = 1;
  logic       tick_en = 1'b0;
  int         tick_ctr = 0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    tick_seen <= tick;
  end

  always @(negedge clk) begin
    if (!tick_en) begin
      tick     = 1'b0;
      tick_ctr = 0;
    end else if (tick_ctr >= tick_period - 1) begin
      tick     = 1'b1;
      tick_ctr = 0;
    end else begin
      tick     = 1'b0;
      tick_ctr = tick_ctr + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [6:0] mk(input logic o, input logic p1, input logic p5,
                                    input logic rd, input logic dn, input logic ur,
                                    input logic bs);
    return {o, p1, p5, rd, dn, ur, bs};
  endfunction

  task automatic push(input int sel, input logic [6:0] rec, input int len, input int rdy);
    exp_t e;
    e.rec = rec;
    e.len = len;
    e.rdy = rdy;
    if (push_cnt < push_lim) begin
      if (sel == 0) exp_a.push_back(e);
      else          exp_b.push_back(e);
    end
    push_cnt++;
  endtask

  // Expected (oe,p1,p5,ready,done,underrun,busy) on each advancing edge of one frame.
  task automatic push_frame(input int sel, input int nb, input logic [31:0] bytes,
                            input int st, input logic ur, input int len, input int rdy,
                            input int lim);
    logic [7:0] b;
    logic       e, o;
    logic       ep1 [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ep5 [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    push_cnt = 0;
    push_lim = lim;
    push(sel, mk(1, 1, 1, 1, 0, 0, 1), 0, 0);
    push(sel, mk(1, 1, 0, 0, 0, 0, 1), 0, 0);
    for (int h = 0; h < 2 * st; h++) push(sel, mk(1, h[0], 0, 0, 0, 0, 1), 0, 0);
    for (int i = 0; i < nb; i++) begin
      b = bytes[31 - 8 * i -: 8];
      for (int j = 0; j < 4; j++) begin
        e = b[7 - 2 * j];
        o = b[6 - 2 * j];
        push(sel, mk(1, 1, e, (i > 0 && j == 0), 0, 0, 1), 0, 0);
        push(sel, mk(1, 0, e, 0, 0, 0, 1), 0, 0);
        push(sel, mk(1, o, 1, 0, 0, 0, 1), 0, 0);
        push(sel, mk(1, o, 0, 0, 0, 0, 1), 0, 0);
      end
    end
    for (int k = 0; k < 7; k++) push(sel, mk(1, ep1[k], ep5[k], 0, 0, 0, 1), 0, 0);
    push(sel, mk(0, 1, 1, 0, 1, ur, 0), len, rdy);
  endtask

  task automatic mon_step(input int sel, input logic [6:0] obs);
    exp_t e;
    int   qs;
    if (!rst) begin
      prev[sel]    = obs;
      oe_cnt[sel]  = 0;
      rdy_cnt[sel] = 0;
      return;
    end
    if (tick_seen) begin
      if (obs[6]) oe_cnt[sel]++;
      if (obs[3]) rdy_cnt[sel]++;
      if (obs[6] || obs[2]) begin
        qs = (sel == 0) ? exp_a.size() : exp_b.size();
        if (qs == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_phase dut%0d: got %b, required no bus activity", sel, obs);
        end else begin
          e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
          check($sformatf("trace dut%0d", sel), 32'(obs), 32'(e.rec));
          if (obs[2]) begin
            if (e.len != 0) begin
              check($sformatf("oe_ticks dut%0d", sel), 32'(oe_cnt[sel]), 32'(e.len));
              check($sformatf("ready_count dut%0d", sel), 32'(rdy_cnt[sel]), 32'(e.rdy));
            end
            oe_cnt[sel]  = 0;
            rdy_cnt[sel] = 0;
          end
        end
      end
    end else begin
      check($sformatf("hold dut%0d", sel), 32'(obs), 32'({prev[sel][6:4], 3'b000, prev[sel][0]}));
    end
    prev[sel] = obs;
  endtask

  always @(negedge clk) begin
    mon_step(0, {a_oe, a_p1, a_p5, a_ready, a_done, a_ur, a_busy});
    mon_step(1, {b_oe, b_p1, b_p5, b_ready, b_done, b_ur, b_busy});
  end

  task automatic send(input int sel, input logic [7:0] d, input logic l, output int rc);
    tx_data = d;
    tx_last = l;
    if (sel == 0) tx_valid = 1'b1;
    else          tx_valid2 = 1'b1;
    rc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((sel == 0) ? a_ready : b_ready) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout dut%0d: got no tx_ready, required one", sel);
    end
  endtask

  task automatic wait_done(input int sel, input logic exp_ur, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0) ? a_done : b_done) begin
        check("done_underrun", 32'((sel == 0) ? a_ur : b_ur), 32'(exp_ur));
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL done_timeout dut%0d: got no done in %0d clks, required done", sel, budget);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1, r2;
    #1 rst = 1'b0;
    #1;
    check("reset_a", 32'({a_ready, a_p1, a_p5, a_oe, a_busy, a_done, a_ur}), 32'(7'b0110000));
    check("reset_b", 32'({b_ready, b_p1, b_p5, b_oe, b_busy, b_done, b_ur}), 32'(7'b0110000));
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Single byte 0xA5, slow tick.
    tick_period = 7;
    tick_en     = 1'b1;
    push_frame(0, 1, 32'hA500_0000, 4, 1'b0, 33, 1, 1000);
    send(0, 8'hA5, 1'b1, r0);
    tx_valid = 1'b0;
    wait_done(0, 1'b0, 2000);

    // Three bytes, continuous tick.
    tick_period = 1;
    repeat (2) @(negedge clk);
    push_frame(0, 3, 32'h00FF_3C00, 4, 1'b0, 65, 3, 1000);
    send(0, 8'h00, 1'b0, r0);
    send(0, 8'hFF, 1'b0, r1);
    send(0, 8'h3C, 1'b1, r2);
    tx_valid = 1'b0;
    check("ready_gap_1_2", 32'(r1 - r0), 32'd26);
    check("ready_gap_2_3", 32'(r2 - r1), 32'd16);
    wait_done(0, 1'b0, 200);

    // Underrun after a non-last byte.
    push_frame(0, 1, 32'h1200_0000, 4, 1'b1, 33, 1, 1000);
    send(0, 8'h12, 1'b0, r0);
    tx_valid = 1'b0;
    wait_done(0, 1'b1, 200);

    // Asynchronous reset after 20 frame ticks.
    push_frame(0, 1, 32'h5A00_0000, 4, 1'b0, 33, 1, 20);
    send(0, 8'h5A, 1'b1, r0);
    tx_valid = 1'b0;
    repeat (19) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_reset", 32'({a_oe, a_p1, a_p5, a_busy, a_done, a_ready}), 32'(6'b011000));
    repeat (3) @(negedge clk);
    check("reset_flush", 32'(exp_a.size()), 32'd0);
    rst = 1'b1;
    push_frame(0, 1, 32'hC300_0000, 4, 1'b0, 33, 1, 1000);
    send(0, 8'hC3, 1'b1, r0);
    tx_valid = 1'b0;
    wait_done(0, 1'b0, 200);

    // tx_valid waiting for a tick.
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    push_frame(0, 1, 32'h8100_0000, 4, 1'b0, 33, 1, 1000);
    tx_data  = 8'h81;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_tick_idle", 32'({a_ready, a_oe, a_busy}), 32'd0);
    end
    tick_en = 1'b1;
    send(0, 8'h81, 1'b1, r0);
    tx_valid = 1'b0;
    check("first_tick_lead", 32'({a_oe, a_busy, a_p1, a_p5}), 32'(4'b1111));
    wait_done(0, 1'b0, 200);

    // START_TOGGLES=2 instance, byte 0x80.
    push_frame(1, 1, 32'h8000_0000, 2, 1'b0, 29, 1, 1000);
    send(1, 8'h80, 1'b1, r0);
    tx_valid2 = 1'b0;
    wait_done(1, 1'b0, 200);

    repeat (3) @(negedge clk);
    check("queue_empty_a", 32'(exp_a.size()), 32'd0);
    check("queue_empty_b", 32'(exp_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
